// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB-to-AXI3 bridge write path.
package apb2axi_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // WS_ADDR_DATA is only reachable when AW and W are allowed to overlap.
  typedef enum logic [2:0] {
    WS_IDLE      = 3'd0,
    WS_ADDR      = 3'd1,
    WS_DATA      = 3'd2,
    WS_RESP      = 3'd3,
    WS_CPL       = 3'd4,
    WS_ADDR_DATA = 3'd5
  } wr_seq_state_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [3:0]            len;
    logic [2:0]            size;
  } wr_req_t;

endpackage

// File: rtl/apb2axi_wr_sequencer.sv
// Single-outstanding AXI3 write sequencer: request -> AW -> W beats -> B -> completion.
// Define APB2AXI_AW_W_OVERLAP_EN to issue AW and W concurrently from one ADDR_DATA state.
module apb2axi_wr_sequencer
  import apb2axi_pkg::*;
#(
  parameter int ID_WIDTH   = AXI_ID_W,
  parameter int ADDR_WIDTH = AXI_ADDR_W,
  parameter int DATA_WIDTH = AXI_DATA_W,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ID_WIDTH-1:0]   req_id,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [3:0]            req_len,
  input  logic [2:0]            req_size,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [DATA_WIDTH-1:0] wd_data,
  input  logic [STRB_WIDTH-1:0] wd_strb,
  output logic [ID_WIDTH-1:0]   AWID,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [3:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic [1:0]            AWBURST,
  output logic [1:0]            AWLOCK,
  output logic [3:0]            AWCACHE,
  output logic [2:0]            AWPROT,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic [STRB_WIDTH-1:0] WSTRB,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [ID_WIDTH-1:0]   BID,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic                  cpl_valid,
  input  logic                  cpl_ready,
  output logic [ID_WIDTH-1:0]   cpl_id,
  output logic [1:0]            cpl_resp,
  output logic                  cpl_id_err,
  output wr_seq_state_e         dbg_state
);

  // Every channel transfers on a cycle where valid && ready are both high at the
  // rising edge; a source never withdraws valid or alters payload before that edge.

  wr_seq_state_e         state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            len_q;
  logic [2:0]            size_q;
  logic [3:0]            beat_q;
  logic [1:0]            cpl_resp_q;
  logic                  cpl_id_err_q;
  logic                  in_data;
  logic                  req_fire, aw_fire, w_fire, b_fire, w_last_fire;
`ifdef APB2AXI_AW_W_OVERLAP_EN
  logic                  aw_done_q, w_done_q;
`endif

  assign req_fire    = req_valid && req_ready;
  assign aw_fire     = AWVALID && AWREADY;
  assign w_fire      = WVALID && WREADY;
  assign w_last_fire = w_fire && WLAST;
  assign b_fire      = BVALID && BREADY;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= WS_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WS_IDLE: begin
`ifdef APB2AXI_AW_W_OVERLAP_EN
        if (req_fire) state_d = WS_ADDR_DATA;
`else
        if (req_fire) state_d = WS_ADDR;
`endif
      end
      WS_ADDR: if (aw_fire) state_d = WS_DATA;
      WS_DATA: if (w_last_fire) state_d = WS_RESP;
`ifdef APB2AXI_AW_W_OVERLAP_EN
      // AW and the last W beat may complete in either order or together.
      WS_ADDR_DATA:
        if ((aw_done_q || aw_fire) && (w_done_q || w_last_fire)) state_d = WS_RESP;
`endif
      WS_RESP: if (b_fire) state_d = WS_CPL;
      WS_CPL:  if (cpl_ready) state_d = WS_IDLE;
      default: state_d = WS_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    AWVALID   = 1'b0;
    in_data   = 1'b0;
    BREADY    = 1'b0;
    cpl_valid = 1'b0;
    case (state_q)
      WS_IDLE: req_ready = 1'b1;
      WS_ADDR: AWVALID   = 1'b1;
      WS_DATA: in_data   = 1'b1;
`ifdef APB2AXI_AW_W_OVERLAP_EN
      WS_ADDR_DATA: begin
        AWVALID = !aw_done_q;
        in_data = !w_done_q;
      end
`endif
      WS_RESP: BREADY    = 1'b1;
      WS_CPL:  cpl_valid = 1'b1;
      default: ;
    endcase
  end

  // W beats stream straight from the data buffer; only the framing is local.
  assign WVALID   = in_data && wd_valid;
  assign wd_ready = in_data && WREADY;
  assign WLAST    = in_data && (beat_q == len_q);
  assign WDATA    = wd_data;
  assign WSTRB    = wd_strb;

  assign AWID    = id_q;
  assign AWADDR  = addr_q;
  assign AWLEN   = len_q;
  assign AWSIZE  = size_q;
  assign AWBURST = AXI_BURST_INCR;
  assign AWLOCK  = 2'b00;
  assign AWCACHE = 4'b0000;
  assign AWPROT  = 3'b000;

  assign cpl_id     = id_q;
  assign cpl_resp   = cpl_resp_q;
  assign cpl_id_err = cpl_id_err_q;
  assign dbg_state  = state_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      beat_q       <= '0;
      cpl_resp_q   <= '0;
      cpl_id_err_q <= 1'b0;
    end else begin
      if (req_fire) begin
        id_q   <= req_id;
        addr_q <= req_addr;
        len_q  <= req_len;
        size_q <= req_size;
        beat_q <= '0;
      end
      if (w_fire) beat_q <= (beat_q == len_q) ? beat_q : beat_q + 4'd1;
      if (b_fire) begin
        cpl_resp_q   <= BRESP;
        cpl_id_err_q <= (BID != id_q);
      end
    end
  end

`ifdef APB2AXI_AW_W_OVERLAP_EN
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (req_fire) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (aw_fire)     aw_done_q <= 1'b1;
      if (w_last_fire) w_done_q  <= 1'b1;
    end
  end
`endif

endmodule
